// File: rtl/ddr3_traffic_checker.sv
// ddr3_traffic_checker
// Write-then-readback self-test engine that sits in front of the DDR3
// memory controller. It writes a known pattern to NUM_OF_TEST_WORDS
// consecutive user addresses, reads every word back, and reports the
// verdict, a saturating mismatch count and the first failing address.
module ddr3_traffic_checker #(
  parameter int                       ADDRESS_BITWIDTH      = 15,
  parameter int                       BANK_ADDRESS_BITWIDTH = 3,
  parameter int                       DQ_BITWIDTH           = 16,
  parameter int                       NUM_OF_TEST_WORDS     = 256,
  parameter int                       TIMEOUT_CYCLES        = 4096,
  parameter logic [DQ_BITWIDTH-1:0]   PATTERN_XOR           = 16'hA5C3
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
  input  logic                                             cmd_ready,
  input  logic                                             rd_data_valid,
  input  logic [DQ_BITWIDTH-1:0]                           o_user_data,
  output logic                                             write_enable,
  output logic                                             read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                           i_user_data,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             pass,
  output logic                                             timeout,
  output logic [15:0]                                      error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_fail_address
);

  localparam int AW   = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int IDXW = $clog2(NUM_OF_TEST_WORDS + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_OF_TEST_WORDS - 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]             state;
  logic [AW-1:0]          base_q;
  logic [IDXW-1:0]        idx;
  logic [TW-1:0]          timer;

  logic [IDXW-1:0]        idx_next;
  logic [AW-1:0]          next_addr;
  logic [DQ_BITWIDTH-1:0] cur_pattern;
  logic [DQ_BITWIDTH-1:0] next_pattern;
  logic                   mismatch;
  logic [15:0]            err_bumped;

  // Next-word address/pattern and the readback comparison for the current word.
  always_comb begin
    idx_next     = idx + 1'b1;
    next_addr    = base_q + AW'(idx_next);
    cur_pattern  = DQ_BITWIDTH'(idx) ^ PATTERN_XOR;
    next_pattern = DQ_BITWIDTH'(idx_next) ^ PATTERN_XOR;
    mismatch     = (o_user_data != cur_pattern);
    err_bumped   = (mismatch && (error_count != 16'hFFFF)) ? error_count + 16'd1 : error_count;
  end

  // Sequencer: state and every output are flops updated together, so the
  // command outputs describe the state the engine is in during that cycle.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking would chain them within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      base_q              <= '0;
      idx                 <= '0;
      timer               <= '0;
      write_enable        <= 1'b0;
      read_enable         <= 1'b0;
      i_user_data_address <= '0;
      i_user_data         <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      error_count         <= '0;
      first_fail_address  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state               <= S_WRITE;
            base_q              <= base_address;
            idx                 <= '0;
            timer               <= '0;
            error_count         <= '0;
            timeout             <= 1'b0;
            done                <= 1'b0;
            pass                <= 1'b0;
            first_fail_address  <= '0;
            busy                <= 1'b1;
            write_enable        <= 1'b1;
            i_user_data_address <= base_address;
            i_user_data         <= PATTERN_XOR;
          end
        end

        S_WRITE: begin
          if (cmd_ready) begin
            if (idx == LAST_IDX) begin
              state               <= S_READ;
              idx                 <= '0;
              write_enable        <= 1'b0;
              read_enable         <= 1'b1;
              i_user_data_address <= base_q;
              i_user_data         <= '0;
            end else begin
              idx                 <= idx_next;
              i_user_data_address <= next_addr;
              i_user_data         <= next_pattern;
            end
          end
        end

        S_READ: begin
          if (cmd_ready) begin
            state       <= S_WAIT_DATA;
            read_enable <= 1'b0;
            timer       <= '0;
          end
        end

        S_WAIT_DATA: begin
          if (rd_data_valid) begin
            error_count <= err_bumped;
            // The held command address is still base+idx for this word.
            if (mismatch && (error_count == 16'd0))
              first_fail_address <= i_user_data_address;
            idx <= idx_next;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_bumped == 16'd0) && !timeout;
            end else begin
              state               <= S_READ;
              read_enable         <= 1'b1;
              i_user_data_address <= next_addr;
            end
          end else if (timer == TIMER_LAST) begin
            state   <= S_DONE;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
